// File: rtl/ibex_register_file_mp.sv
// Flop-based multi-port register file: optional write bypass, dummy-instruction
// shadow x0, and a wipe sequencer that zeroes one register per cycle on request.
module ibex_register_file_mp #(
    parameter bit          RV32E             = 1'b0,
    parameter int unsigned DataWidth         = 32,
    parameter int unsigned NumRdPorts        = 2,
    parameter int unsigned NumWrPorts        = 1,
    parameter bit          WrBypass          = 1'b0,
    parameter bit          DummyInstructions = 1'b0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            dummy_instr_id_i,
    input  logic [NumRdPorts*5-1:0]         raddr_i,
    output logic [NumRdPorts*DataWidth-1:0] rdata_o,
    input  logic [NumWrPorts-1:0]           we_i,
    input  logic [NumWrPorts*5-1:0]         waddr_i,
    input  logic [NumWrPorts*DataWidth-1:0] wdata_i,
    input  logic                            wipe_req_i,
    output logic                            wipe_busy_o,
    output logic                            wipe_done_o,
    output logic                            wr_drop_o
);
    localparam int unsigned NUM_WORDS = RV32E ? 16 : 32;
    localparam int unsigned ADDR_W    = RV32E ? 4 : 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WIPE = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [ADDR_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]    w_cnt_nxt;
    logic [DataWidth-1:0] r_mem [NUM_WORDS];
    logic [DataWidth-1:0] r_shadow;
    logic                 w_busy;
    logic                 w_wipe_start;
    logic [NumWrPorts-1:0] w_we;
    logic [ADDR_W-1:0]    w_waddr [NumWrPorts];
    logic [DataWidth-1:0] w_wdata [NumWrPorts];
    logic [ADDR_W-1:0]    w_raddr [NumRdPorts];
    logic [DataWidth-1:0] w_rdata [NumRdPorts];
    logic                 w_unused_addr;

    // Port unpacking; address bits above ADDR_W are ignored
    for (genvar p = 0; p < NumWrPorts; p++) begin : g_wr
        assign w_waddr[p] = waddr_i[5*p +: ADDR_W];
        assign w_wdata[p] = wdata_i[DataWidth*p +: DataWidth];
    end
    for (genvar k = 0; k < NumRdPorts; k++) begin : g_rd
        assign w_raddr[k]                       = raddr_i[5*k +: ADDR_W];
        assign rdata_o[DataWidth*k +: DataWidth] = w_rdata[k];
    end
    assign w_unused_addr = ^{raddr_i, waddr_i};

    assign w_busy       = (r_state == ST_WIPE);
    assign w_wipe_start = (r_state == ST_IDLE) && wipe_req_i;
    assign w_we         = w_busy ? '0 : we_i;
    assign wipe_busy_o  = w_busy;
    assign wipe_done_o  = (r_state == ST_DONE);
    assign wr_drop_o    = w_busy && (|we_i);

    // Wipe sequencer next-state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (wipe_req_i) begin
                    w_state_nxt = ST_WIPE;
                    w_cnt_nxt   = ADDR_W'(1);
                end
            end
            ST_WIPE: begin
                w_cnt_nxt = r_cnt + ADDR_W'(1);
                if (r_cnt == ADDR_W'(NUM_WORDS - 1)) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = ADDR_W'(1);
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, storage and shadow x0; higher-numbered write ports win on conflict
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_cnt    <= ADDR_W'(1);
            r_shadow <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            for (int p = 0; p < NumWrPorts; p++) begin
                if (w_we[p]) begin
                    if (w_waddr[p] != '0) begin
                        r_mem[w_waddr[p]] <= w_wdata[p];
                    end else if (DummyInstructions && dummy_instr_id_i) begin
                        r_shadow <= w_wdata[p];
                    end
                end
            end
            if (w_busy) begin
                r_mem[r_cnt] <= '0;
            end
            if (w_wipe_start) begin
                r_shadow <= '0;
            end
        end
    end

    // Combinational read with optional same-cycle forwarding
    always_comb begin
        for (int k = 0; k < NumRdPorts; k++) begin
            w_rdata[k] = r_mem[w_raddr[k]];
            if (w_raddr[k] == '0) begin
                w_rdata[k] = (DummyInstructions && dummy_instr_id_i) ? r_shadow : '0;
            end else if (WrBypass) begin
                for (int p = 0; p < NumWrPorts; p++) begin
                    if (w_we[p] && (w_waddr[p] == w_raddr[k])) begin
                        w_rdata[k] = w_wdata[p];
                    end
                end
            end
        end
    end

endmodule
